// File: rtl/force_wb_scheduler_if.sv
// Bundle of the per-source writeback handshake and the shared network port.
// master: the scheduler side. slave: the sources and the network.
interface force_wb_scheduler_if #(
  parameter int NUM_SRC  = 2,
  parameter int WB_WIDTH = 112
);
  logic [NUM_SRC-1:0][WB_WIDTH-1:0] src_wb_out;
  logic [NUM_SRC-1:0]               src_wb_valid;
  logic [NUM_SRC-1:0]               src_all_ref_issued;
  logic [NUM_SRC-1:0]               src_ready;
  logic [NUM_SRC-1:0]               src_start_wb;
  logic [WB_WIDTH-1:0]              net_out;
  logic                             net_valid;
  logic                             net_ready;

  modport master (
    input  src_wb_out, src_wb_valid, src_all_ref_issued, net_ready,
    output src_ready, src_start_wb, net_out, net_valid
  );

  modport slave (
    output src_wb_out, src_wb_valid, src_all_ref_issued, net_ready,
    input  src_ready, src_start_wb, net_out, net_valid
  );
endinterface

// File: rtl/force_wb_scheduler.sv
// Buffers force writebacks from NUM_SRC sources and funnels them round-robin onto one network port.
// Define FORCE_WB_OVF_DETECT_EN to get a sticky overflow flag for words refused by a full buffer.
module force_wb_scheduler #(
  parameter int NUM_SRC    = 2,
  parameter int WB_WIDTH   = 112,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  phase_done,
  force_wb_scheduler_if.master  bus,
  output logic                  busy,
  output logic                  wb_done,
  output logic                  overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic [1:0] {IDLE, START, DRAIN, FLUSH} state_t;

  state_t state, next_state;
  logic [SW-1:0] cur_src, next_src;
  logic [SW-1:0] rr_ptr, sel;
  logic any_valid;
  logic [NUM_SRC-1:0] push, pop, nonempty, start_vec;
  logic [NUM_SRC-1:0][WB_WIDTH-1:0] head;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    logic [WB_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;

    assign nonempty[g] = (count != '0);
    assign head[g] = mem[rd_ptr];
    assign pop[g] = any_valid && bus.net_ready && (sel == SW'(g));
    // A full buffer still accepts when its head leaves in the same cycle.
    assign push[g] = bus.src_wb_valid[g] && ((count < CW'(FIFO_DEPTH)) || pop[g]);
    assign bus.src_ready[g] = (count < CW'(FIFO_DEPTH - 1));

    always_ff @(posedge clk) begin
      if (push[g]) mem[wr_ptr] <= bus.src_wb_out[g];
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push[g]) wr_ptr <= wr_ptr + 1'b1;
        if (pop[g])  rd_ptr <= rd_ptr + 1'b1;
        count <= count + CW'(push[g]) - CW'(pop[g]);
      end
    end
  end

  // Scan downward so the closest non-empty source at or after rr_ptr wins.
  always_comb begin
    int idx;
    idx = 0;
    sel = rr_ptr;
    any_valid = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (nonempty[SW'(idx)]) begin
        sel = SW'(idx);
        any_valid = 1'b1;
      end
    end
  end

  assign bus.net_valid = any_valid;
  assign bus.net_out   = any_valid ? head[sel] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= '0;
    end else if (any_valid && bus.net_ready) begin
      rr_ptr <= (sel == SW'(NUM_SRC - 1)) ? '0 : sel + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cur_src <= '0;
    end else begin
      state   <= next_state;
      cur_src <= next_src;
    end
  end

  always_comb begin
    next_state = state;
    next_src   = cur_src;
    start_vec  = '0;
    wb_done    = 1'b0;
    case (state)
      IDLE: begin
        if (phase_done) begin
          next_state = START;
          next_src   = '0;
        end
      end
      START: begin
        start_vec[cur_src] = 1'b1;
        next_state = DRAIN;
      end
      DRAIN: begin
        if (bus.src_all_ref_issued[cur_src]) begin
          if (cur_src == SW'(NUM_SRC - 1)) begin
            next_state = FLUSH;
          end else begin
            next_src   = cur_src + 1'b1;
            next_state = START;
          end
        end
      end
      FLUSH: begin
        if (nonempty == '0) begin
          wb_done    = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign bus.src_start_wb = start_vec;
  assign busy = (state != IDLE);

`ifdef FORCE_WB_OVF_DETECT_EN
  logic [NUM_SRC-1:0] refused;
  assign refused = bus.src_wb_valid & ~push;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) overflow <= 1'b0;
    else if (|refused) overflow <= 1'b1;
  end
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_force_wb_scheduler.sv
// Directed bench for force_wb_scheduler: per-source scoreboard queues checked as words leave the network port.
module tb_force_wb_scheduler;
  localparam int NUM_SRC    = 2;
  localparam int WB_WIDTH   = 112;
  localparam int FIFO_DEPTH = 8;
`ifdef FORCE_WB_OVF_DETECT_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic phase_done = 1'b0;
  logic busy, wb_done, overflow;

  int errors = 0;
  int checks = 0;
  int wb_done_cnt = 0;
  int seq = 0;
  int base_done = 0;
  int n = 0;
  logic alt_check = 1'b0;
  logic [3:0] last_src = 4'd0;
  logic [WB_WIDTH-1:0] last_w0;
  logic [WB_WIDTH-1:0] exp_a, exp_b, exp_c;
  logic [WB_WIDTH-1:0] q0[$];
  logic [WB_WIDTH-1:0] q1[$];

  force_wb_scheduler_if #(.NUM_SRC(NUM_SRC), .WB_WIDTH(WB_WIDTH)) bus ();

  force_wb_scheduler #(
    .NUM_SRC(NUM_SRC), .WB_WIDTH(WB_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst_n),
    .phase_done(phase_done),
    .bus(bus),
    .busy(busy),
    .wb_done(wb_done),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WB_WIDTH-1:0] make_word(input logic [3:0] src);
    seq++;
    return {src, seq[11:0], $urandom(), $urandom(), $urandom()};
  endfunction

  // Drive one cycle of inputs just after a rising edge; accepted words go to the scoreboard.
  task automatic apply_stimulus(input logic [1:0] valid, input logic [1:0] accept,
                                input logic nr, input logic pd, input logic [1:0] ref_iss);
    logic [WB_WIDTH-1:0] w0, w1;
    @(posedge clk);
    #1;
    w0 = make_word(4'd0);
    w1 = make_word(4'd1);
    bus.src_wb_out[0] = w0;
    bus.src_wb_out[1] = w1;
    bus.src_wb_valid = valid;
    bus.net_ready = nr;
    bus.src_all_ref_issued = ref_iss;
    phase_done = pd;
    last_w0 = w0;
    if (accept[0]) q0.push_back(w0);
    if (accept[1]) q1.push_back(w1);
  endtask

  task automatic wait_empty(input string tag);
    int k;
    k = 0;
    while ((q0.size() != 0 || q1.size() != 0) && k < 60) begin
      @(negedge clk);
      k++;
    end
    check_output(tag, q0.size() + q1.size(), 0);
  endtask

  always @(negedge clk) begin
    logic [3:0] s;
    if (rst_n && wb_done) wb_done_cnt++;
    if (rst_n && bus.net_valid && bus.net_ready) begin
      s = bus.net_out[WB_WIDTH-1 -: 4];
      if (s == 4'd0) begin
        check_output("sb_q0_has_entry", q0.size() != 0, 1);
        if (q0.size() != 0) check_output("sb_src0_word", bus.net_out, q0.pop_front());
      end else if (s == 4'd1) begin
        check_output("sb_q1_has_entry", q1.size() != 0, 1);
        if (q1.size() != 0) check_output("sb_src1_word", bus.net_out, q1.pop_front());
      end else begin
        check_output("sb_src_id_valid", s < 4'd2, 1);
      end
      if (alt_check) check_output("rr_alternate", s != last_src, 1);
      last_src = s;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.src_wb_out = '0;
    bus.src_wb_valid = '0;
    bus.src_all_ref_issued = '0;
    bus.net_ready = 1'b0;

    // Reset values
    @(negedge clk);
    check_output("rst_net_valid", bus.net_valid, 0);
    check_output("rst_net_out", bus.net_out, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_wb_done", wb_done, 0);
    check_output("rst_src_ready", bus.src_ready, 2'b11);
    check_output("rst_start_wb", bus.src_start_wb, 2'b00);
    check_output("rst_overflow", overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(2'b00, 2'b00, 1'b1, 1'b0, 2'b00);

    // Three words from src0 appear on consecutive cycles right after their push
    apply_stimulus(2'b01, 2'b01, 1'b1, 1'b0, 2'b00);
    exp_a = last_w0;
    apply_stimulus(2'b01, 2'b01, 1'b1, 1'b0, 2'b00);
    exp_b = last_w0;
    @(negedge clk);
    check_output("lat_word0_valid", bus.net_valid, 1);
    check_output("lat_word0", bus.net_out, exp_a);
    apply_stimulus(2'b01, 2'b01, 1'b1, 1'b0, 2'b00);
    exp_c = last_w0;
    @(negedge clk);
    check_output("lat_word1", bus.net_out, exp_b);
    apply_stimulus(2'b00, 2'b00, 1'b1, 1'b0, 2'b00);
    @(negedge clk);
    check_output("lat_word2", bus.net_out, exp_c);
    apply_stimulus(2'b00, 2'b00, 1'b1, 1'b0, 2'b00);
    @(negedge clk);
    check_output("lat_empty_after", bus.net_valid, 0);
    wait_empty("t1_drain");

    // Both sources streaming: output must alternate
    alt_check = 1'b1;
    repeat (6) apply_stimulus(2'b11, 2'b11, 1'b1, 1'b0, 2'b00);
    @(negedge clk);
    check_output("t2_src_ready", bus.src_ready, 2'b11);
    apply_stimulus(2'b00, 2'b00, 1'b1, 1'b0, 2'b00);
    wait_empty("t2_drain");
    alt_check = 1'b0;
    check_output("t2_overflow", overflow, 0);

    // Writeback round with spurious inputs during DRAIN
    base_done = wb_done_cnt;
    apply_stimulus(2'b00, 2'b00, 1'b1, 1'b1, 2'b00);
    apply_stimulus(2'b00, 2'b00, 1'b1, 1'b0, 2'b00);
    @(negedge clk);
    check_output("t3_start0", bus.src_start_wb, 2'b01);
    check_output("t3_busy_start", busy, 1);
    apply_stimulus(2'b00, 2'b00, 1'b1, 1'b1, 2'b10);
    @(negedge clk);
    check_output("t3_start0_one_cycle", bus.src_start_wb, 2'b00);
    apply_stimulus(2'b00, 2'b00, 1'b1, 1'b0, 2'b00);
    @(negedge clk);
    check_output("t3_spurious_ignored", bus.src_start_wb, 2'b00);
    check_output("t3_busy_drain", busy, 1);
    repeat (14) apply_stimulus(2'b00, 2'b00, 1'b1, 1'b0, 2'b00);
    apply_stimulus(2'b00, 2'b00, 1'b1, 1'b0, 2'b01);
    apply_stimulus(2'b00, 2'b00, 1'b1, 1'b0, 2'b00);
    @(negedge clk);
    check_output("t3_start1", bus.src_start_wb, 2'b10);
    apply_stimulus(2'b11, 2'b11, 1'b0, 1'b0, 2'b00);
    apply_stimulus(2'b00, 2'b00, 1'b0, 1'b0, 2'b00);
    @(negedge clk);
    check_output("t3_start1_one_cycle", bus.src_start_wb, 2'b00);
    repeat (12) apply_stimulus(2'b00, 2'b00, 1'b0, 1'b0, 2'b00);
    apply_stimulus(2'b00, 2'b00, 1'b0, 1'b0, 2'b10);
    apply_stimulus(2'b00, 2'b00, 1'b0, 1'b0, 2'b00);
    @(negedge clk);
    check_output("t3_flush_waits", wb_done, 0);
    check_output("t3_flush_busy", busy, 1);
    check_output("t3_flush_pending", bus.net_valid, 1);
    apply_stimulus(2'b00, 2'b00, 1'b1, 1'b0, 2'b00);
    n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_output("t3_round_ends", busy, 0);
    check_output("t3_one_wb_done", wb_done_cnt - base_done, 1);
    wait_empty("t3_drain");

    // Fill src0 with the network stalled; the ninth word is dropped
    apply_stimulus(2'b01, 2'b01, 1'b0, 1'b0, 2'b00);
    for (int i = 2; i <= 9; i++) begin
      apply_stimulus(2'b01, (i <= FIFO_DEPTH) ? 2'b01 : 2'b00, 1'b0, 1'b0, 2'b00);
      @(negedge clk);
      check_output($sformatf("t4_ready_cnt%0d", i - 1), bus.src_ready[0], (i - 1) < (FIFO_DEPTH - 1));
      check_output($sformatf("t4_no_ovf_cnt%0d", i - 1), overflow, 0);
    end
    apply_stimulus(2'b00, 2'b00, 1'b0, 1'b0, 2'b00);
    @(negedge clk);
    check_output("t4_ready_full", bus.src_ready[0], 0);
    check_output("t4_overflow", overflow, OVF_EXP);
    apply_stimulus(2'b00, 2'b00, 1'b1, 1'b0, 2'b00);
    wait_empty("t4_drain");
    check_output("t4_overflow_sticky", overflow, OVF_EXP);

    // Reset in the middle of a round with five words buffered
    base_done = wb_done_cnt;
    apply_stimulus(2'b00, 2'b00, 1'b0, 1'b1, 2'b00);
    repeat (5) apply_stimulus(2'b01, 2'b01, 1'b0, 1'b0, 2'b00);
    apply_stimulus(2'b00, 2'b00, 1'b0, 1'b0, 2'b00);
    @(negedge clk);
    check_output("t5_pre_valid", bus.net_valid, 1);
    check_output("t5_pre_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_output("t5_rst_net_valid", bus.net_valid, 0);
    check_output("t5_rst_net_out", bus.net_out, 0);
    check_output("t5_rst_busy", busy, 0);
    check_output("t5_rst_src_ready", bus.src_ready, 2'b11);
    check_output("t5_rst_overflow", overflow, 0);
    q0.delete();
    q1.delete();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check_output("t5_no_wb_done", wb_done_cnt - base_done, 0);
    check_output("t5_idle_after", busy, 0);
    check_output("t5_empty_after", bus.net_valid, 0);
    check_output("final_queues_empty", q0.size() + q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/force_wb_scheduler.md
FORCE_WB_SCHEDULER -- requirements
Module: force_wb_scheduler

Interface
REQ-001 SHALL have parameter NUM_SRC, default 2, meaning number of force writeback sources sharing one network port.
REQ-002 SHALL have parameter WB_WIDTH, default 112, meaning writeback word width ({16-bit id, 3x32-bit force}).
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, meaning per-source buffer depth (power of 2, >=4).
REQ-004 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port phase_done  input  1  one-cycle pulse: force evaluation for the current phase is complete.
REQ-007 SHALL have port src_wb_out  input  NUM_SRC x WB_WIDTH  per-source writeback word.
REQ-008 SHALL have port src_wb_valid  input  NUM_SRC  per-source word valid.
REQ-009 SHALL have port src_all_ref_issued  input  NUM_SRC  per-source one-cycle pulse: all reference writebacks issued.
REQ-010 SHALL have port src_ready  output  NUM_SRC  per-source buffer can accept.
REQ-011 SHALL have port src_start_wb  output  NUM_SRC  per-source one-cycle start-writeback pulse.
REQ-012 SHALL have port net_out  output  WB_WIDTH  word to network injection.
REQ-013 SHALL have port net_valid  output  1  net_out valid.
REQ-014 SHALL have port net_ready  input  1  network accepts word this cycle.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-016 SHALL have port wb_done  output  1  one-cycle pulse when a full writeback round completes.
REQ-017 SHALL have port overflow  output  1  sticky: a word arrived to a full buffer.

Function
REQ-018 SHALL hold one FIFO per source; push when src_wb_valid[k] and (count<FIFO_DEPTH or pop of k in same cycle).
REQ-019 SHALL drive src_ready[k] combinationally high iff count[k] < FIFO_DEPTH-1 (one-slot margin for unthrottled neighbor forces).
REQ-020 SHALL select output source by round-robin pointer; net_valid high iff any FIFO non-empty; net_out = head of the first non-empty FIFO at or after the pointer.
REQ-021 SHALL pop selected head when net_valid and net_ready; pointer then moves to selected index+1 modulo NUM_SRC; no pop, no move.
REQ-022 SHALL give minimum latency of 1 cycle: word pushed at edge N is on net_out during cycle N+1 if selected.
REQ-023 SHALL implement FSM IDLE, START, DRAIN, FLUSH: IDLE->START on phase_done with k=0.
REQ-024 SHALL in START assert src_start_wb[k] for exactly one cycle, then go to DRAIN.
REQ-025 SHALL in DRAIN wait for src_all_ref_issued[k]; then k<NUM_SRC-1 -> START with k+1, else -> FLUSH.
REQ-026 SHALL in FLUSH wait until all FIFOs empty, then pulse wb_done one cycle and return to IDLE.
REQ-027 SHALL ignore phase_done when not in IDLE; src_all_ref_issued for index !=k or outside DRAIN is ignored.
REQ-028 SHALL continue buffering and forwarding from all sources in every state (neighbor forces never blocked by FSM).

Reset
REQ-029 SHALL on rst low immediately clear all FIFOs, pointer=0, k=0, state=IDLE, overflow=0.
REQ-030 SHALL during reset drive src_start_wb=0, net_valid=0, busy=0, wb_done=0, src_ready=all ones; net_out=0.
REQ-031 SHALL on reset mid-round abandon the round with no wb_done.

Configuration
REQ-032 SHALL, with FORCE_WB_OVF_DETECT_EN defined, set overflow sticky when a push is refused, dropping that word.
REQ-033 SHALL, without FORCE_WB_OVF_DETECT_EN, tie overflow to 0 and drop refused words silently.

Verification
REQ-034 SHALL cover: src0 valid 3 words, src1 idle, net_ready=1 -> 3 words out on cycles N+1..N+3 in order.
REQ-035 SHALL cover: both sources valid every cycle, net_ready=1 -> net_out alternates src0,src1; no overflow.
REQ-036 SHALL cover: phase_done pulse, src_all_ref_issued[0] 20 cycles later, [1] 15 later -> src_start_wb[0] at cycle 1, src_start_wb[1] one cycle after [0] issued, wb_done after FIFOs empty.
REQ-037 SHALL cover: net_ready=0, src0 valid 9 consecutive cycles (depth 8) -> src_ready[0] low at count 7, 9th word dropped, overflow=1 (macro on) / 0 (macro off).
REQ-038 SHALL cover: rst low during DRAIN with 5 words buffered -> net_valid=0 immediately, state IDLE, no wb_done.
REQ-039 SHALL cover: phase_done during DRAIN -> ignored, exactly one wb_done for the round.
